// File: rtl/bcd_to_bin_seq.sv
// Iterative packed-BCD to binary converter (reverse double-dabble).
// One right shift per clock, then every BCD digit >= 8 is reduced by 3.

module sub3_if_gte8 (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);
    assign fixed = (digit >= 4'd8) ? digit - 4'd3 : digit;
endmodule

module bcd_to_bin_seq #(
    parameter int NDIGITS = 3,
    parameter int WIDTH   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   BCD_in,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       BIN_out,
    output logic                   err
);
    localparam int BW = 4 * NDIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t           state_reg, state_next;
    logic [BW-1:0]    bcd_reg, bcd_next;
    logic [WIDTH-1:0] bin_reg, bin_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             err_pend_reg, err_pend_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [WIDTH-1:0] bin_out_reg, bin_out_next;

    logic [BW-1:0]      shifted_bcd;
    logic [BW-1:0]      corrected_bcd;
    logic [WIDTH-1:0]   shifted_bin;
    logic [NDIGITS-1:0] digit_bad;

    // The bcd LSB falls into the binary MSB; a zero enters the bcd MSB.
    assign shifted_bcd = {1'b0, bcd_reg[BW-1:1]};
    assign shifted_bin = {bcd_reg[0], bin_reg[WIDTH-1:1]};

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
            sub3_if_gte8 u_fix (
                .digit (shifted_bcd[4*gi +: 4]),
                .fixed (corrected_bcd[4*gi +: 4])
            );
            assign digit_bad[gi] = (BCD_in[4*gi +: 4] > 4'd9);
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        bcd_next      = bcd_reg;
        bin_next      = bin_reg;
        cnt_next      = cnt_reg;
        err_pend_next = err_pend_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        err_next      = err_reg;
        bin_out_next  = bin_out_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    bcd_next      = BCD_in;
                    bin_next      = '0;
                    cnt_next      = '0;
                    err_pend_next = |digit_bad;
                    busy_next     = 1'b1;
                    state_next    = CONV;
                end
            end
            CONV: begin
                bcd_next = corrected_bcd;
                bin_next = shifted_bin;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    // Invalid operands still run the full latency but report zero.
                    bin_out_next = err_pend_reg ? '0 : shifted_bin;
                    err_next     = err_pend_reg;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    cnt_next     = '0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            bcd_reg      <= '0;
            bin_reg      <= '0;
            cnt_reg      <= '0;
            err_pend_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            bin_out_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            bcd_reg      <= bcd_next;
            bin_reg      <= bin_next;
            cnt_reg      <= cnt_next;
            err_pend_reg <= err_pend_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            bin_out_reg  <= bin_out_next;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign BIN_out = bin_out_reg;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.

module tb_bcd_to_bin_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] BCD_in = '0;
    logic        busy;
    logic        done;
    logic [9:0]  BIN_out;
    logic        err;

    typedef struct {
        logic [9:0] bin;
        logic       err;
        int         due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle_cnt = 0;
    logic done_prev = 1'b0;

    bcd_to_bin_seq #(.NDIGITS(3), .WIDTH(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .BCD_in  (BCD_in),
        .busy    (busy),
        .done    (done),
        .BIN_out (BIN_out),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: one line per completed conversion.
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 BIN_out=%0d expected no done", BIN_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("done at cycle %0d: BIN_out=%0d err=%0b (expected %0d/%0b)",
                             cycle_cnt, BIN_out, err, e.bin, e.err);
                    check("bin_out", int'(BIN_out), int'(e.bin));
                    check("err", int'(err), int'(e.err));
                    check("latency", cycle_cnt, e.due);
                end
                if (done_prev) check("done_width", 2, 1);
            end
            done_prev = done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 0, 1);
    endtask

    // Issue one conversion; returns at the negedge after the accepting edge.
    task automatic convert(input logic [11:0] v, input logic [9:0] eb,
                           input logic e, input bit expect_done);
        exp_t x;
        wait_idle();
        BCD_in = v;
        start  = 1'b1;
        x.bin = eb;
        x.err = e;
        x.due = cycle_cnt + 11;
        if (expect_done) q.push_back(x);
        @(negedge clk);
        start  = 1'b0;
        BCD_in = 12'hFFF;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("drain_timeout", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_bin_out", int'(BIN_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // 0x999 with busy profile over the whole conversion
        convert(12'h999, 10'd999, 1'b0, 1'b1);
        check("busy_c1", int'(busy), 1);
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            check("busy_mid", int'(busy), 1);
        end
        @(negedge clk);
        check("busy_after", int'(busy), 0);
        drain();

        convert(12'h000, 10'd0,   1'b0, 1'b1); drain();
        convert(12'h001, 10'd1,   1'b0, 1'b1); drain();
        convert(12'h255, 10'd255, 1'b0, 1'b1); drain();
        convert(12'h512, 10'd512, 1'b0, 1'b1); drain();
        convert(12'h1A3, 10'd0,   1'b1, 1'b1); drain();
        convert(12'h042, 10'd42,  1'b0, 1'b1); drain();

        // start re-pulsed while busy must be ignored
        convert(12'h123, 10'd123, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        BCD_in = 12'h777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);

        // asynchronous abort mid-conversion
        convert(12'h888, 10'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err), 0);
        check("abort_bin_out", int'(BIN_out), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_idle", int'(busy), 0);
        convert(12'h888, 10'd888, 1'b0, 1'b1); drain();

        // start held high: back-to-back accepts
        wait_idle();
        BCD_in = 12'h050;
        start  = 1'b1;
        c = cycle_cnt;
        q.push_back('{bin: 10'd50,  err: 1'b0, due: c + 11});
        q.push_back('{bin: 10'd999, err: 1'b0, due: c + 22});
        @(negedge clk);
        BCD_in = 12'h999;
        repeat (11) @(negedge clk);
        start  = 1'b0;
        BCD_in = 12'h000;
        drain();
        repeat (12) @(negedge clk);

        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
